// File: rtl/bkm_digit_gen.sv
// BKM signed-digit generator: emits STEPS (d_x, d_y) pairs per operation with valid/ready handshake.
// Optional accepted-nonzero-pair counter port nz_cnt when BKM_DIGIT_GEN_NZ_CNT_EN is defined.
module bkm_digit_gen #(
    parameter int W     = 16,
    parameter int STEPS = 16,
    parameter int THR   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [W-1:0]  x_in,
    input  logic signed [W-1:0]  y_in,
    output logic                 busy,
    output logic                 digit_valid,
    input  logic                 digit_ready,
    output logic [1:0]           d_x,
    output logic [1:0]           d_y,
    output logic                 done
`ifdef BKM_DIGIT_GEN_NZ_CNT_EN
    ,
    output logic [$clog2(STEPS+1)-1:0] nz_cnt
`endif
);

    localparam int RW = W + 2;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic signed [RW-1:0] THR_P  = RW'(THR);
    localparam logic signed [RW-1:0] THR_N  = -THR_P;
    localparam logic signed [RW-1:0] THR_X4 = RW'(4 * THR);
    localparam logic [CW-1:0]        LAST   = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic signed [RW-1:0]  rx_q, ry_q, rx_d, ry_d;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q, valid_q, done_q;
    logic [1:0]            selx, sely;
    logic                  hs;

    function automatic logic [1:0] sel(input logic signed [RW-1:0] r);
        if (r >= THR_P)     return 2'b01;
        else if (r < THR_N) return 2'b11;
        else                return 2'b00;
    endfunction

    // r <- 2r - d*4*THR, wrapping modulo 2**RW
    function automatic logic signed [RW-1:0] upd(input logic signed [RW-1:0] r,
                                                 input logic [1:0] d);
        case (d)
            2'b01:   return (r <<< 1) - THR_X4;
            2'b11:   return (r <<< 1) + THR_X4;
            default: return r <<< 1;
        endcase
    endfunction

    always_comb begin
        selx = sel(rx_q);
        sely = sel(ry_q);
        rx_d = upd(rx_q, selx);
        ry_d = upd(ry_q, sely);
        hs   = valid_q & digit_ready;
        d_x  = valid_q ? selx : 2'b00;
        d_y  = valid_q ? sely : 2'b00;
    end

    assign busy        = busy_q;
    assign digit_valid = valid_q;
    assign done        = done_q;

`ifdef BKM_DIGIT_GEN_NZ_CNT_EN
    logic [$clog2(STEPS+1)-1:0] nz_q;
    assign nz_cnt = nz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= '0;
        end else if (state_q == IDLE && start) begin
            nz_q <= '0;
        end else if (state_q == RUN && hs && (selx != 2'b00 || sely != 2'b00)) begin
            nz_q <= nz_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rx_q    <= RW'(x_in);
                        ry_q    <= RW'(y_in);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        rx_q <= rx_d;
                        ry_q <= ry_d;
                        if (cnt_q == LAST) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bkm_digit_gen.sv
// Bench for bkm_digit_gen: table of operations scored against an integer residual model,
// plus hand-written reset-abort sequence.
module tb_bkm_digit_gen;

    localparam int STEPS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [15:0] x_in = '0, y_in = '0;
    logic busy, digit_valid, digit_ready = 1'b0, done;
    logic [1:0] d_x, d_y;
`ifdef BKM_DIGIT_GEN_NZ_CNT_EN
    logic [$clog2(STEPS+1)-1:0] nz_cnt;
`endif

    bkm_digit_gen #(.W(16), .STEPS(STEPS), .THR(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .digit_valid(digit_valid), .digit_ready(digit_ready),
        .d_x(d_x), .d_y(d_y), .done(done)
`ifdef BKM_DIGIT_GEN_NZ_CNT_EN
        , .nz_cnt(nz_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, done_cnt = 0, exp_nz = 0;
    logic [3:0] exp_q[$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap18(input int r);
        int v;
        v = r & 32'h3FFFF;
        if (v >= 131072) v -= 262144;
        return v;
    endfunction

    function automatic int dsel(input int r);
        if (r >= 4096) return 1;
        if (r < -4096) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] enc(input int d);
        return (d == 1) ? 2'b01 : (d == -1) ? 2'b11 : 2'b00;
    endfunction

    task automatic push_model(input int x, input int y);
        int rx, ry, dx, dy;
        rx = x; ry = y; exp_nz = 0;
        for (int i = 0; i < STEPS; i++) begin
            dx = dsel(rx); dy = dsel(ry);
            exp_q.push_back({enc(dx), enc(dy)});
            if (dx != 0 || dy != 0) exp_nz++;
            rx = wrap18(2 * rx - dx * 16384);
            ry = wrap18(2 * ry - dy * 16384);
        end
    endtask

    // mode: 0 = ready high, 1 = toggling, 2 = random
    task automatic run_op(input logic signed [15:0] x, input logic signed [15:0] y,
                          input logic [1:0] dx0, input logic [1:0] dy0,
                          input int mode, input bit glitch);
        int hs = 0, cyc = 0, dn0;
        logic [1:0] px = '0, py = '0;
        bit stalled = 0;
        logic [3:0] e;
        dn0 = done_cnt;
        exp_q.delete();
        push_model(int'(x), int'(y));
        @(negedge clk); start = 1'b1; x_in = x; y_in = y;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        while (hs < STEPS && cyc < 200) begin
            if (stalled) begin
                chk("stall_dx_stable", int'(d_x), int'(px));
                chk("stall_dy_stable", int'(d_y), int'(py));
            end
            chk("busy_in_run", int'(busy), 1);
            chk("valid_in_run", int'(digit_valid), 1);
            digit_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (glitch && cyc == 3) begin
                start = 1'b1; x_in = ~x; y_in = ~y;
            end else begin
                start = 1'b0;
            end
            if (digit_valid && digit_ready) begin
                e = exp_q.pop_front();
                if (hs == 0) begin
                    chk("first_dx", int'(d_x), int'(dx0));
                    chk("first_dy", int'(d_y), int'(dy0));
                end
                chk("dx", int'(d_x), int'(e[3:2]));
                chk("dy", int'(d_y), int'(e[1:0]));
                hs++;
                stalled = 0;
            end else begin
                stalled = digit_valid;
                px = d_x; py = d_y;
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        digit_ready = 1'b0;
        chk("handshake_budget", hs, STEPS);
        chk("done_pulse", int'(done), 1);
        chk("busy_in_done", int'(busy), 1);
        chk("valid_in_done", int'(digit_valid), 0);
        chk("dx_zero_in_done", int'(d_x), 0);
        @(negedge clk);
        chk("done_cleared", int'(done), 0);
        chk("busy_fell", int'(busy), 0);
        chk("done_count", done_cnt - dn0, 1);
`ifdef BKM_DIGIT_GEN_NZ_CNT_EN
        chk("nz_cnt", int'(nz_cnt), exp_nz);
`endif
    endtask

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [1:0] dx0;
        logic [1:0] dy0;
        int mode;
        bit glitch;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'sd5000,   16'sd0,     2'b01, 2'b00, 0, 1'b0};
        vecs[1] = '{-16'sd4096,  16'sd4096,  2'b00, 2'b01, 1, 1'b0};
        vecs[2] = '{16'sd4095,   -16'sd4097, 2'b00, 2'b11, 2, 1'b0};
        vecs[3] = '{-16'sd5000,  16'sd32767, 2'b11, 2'b01, 0, 1'b1};
        vecs[4] = '{16'sd0,      16'sd0,     2'b00, 2'b00, 1, 1'b0};
        vecs[5] = '{-16'sd32768, 16'sd4096,  2'b11, 2'b01, 2, 1'b0};

        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dx", int'(d_x), 0);
        chk("rst_dy", int'(d_y), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].x, vecs[i].y, vecs[i].dx0, vecs[i].dy0, vecs[i].mode, vecs[i].glitch);

        // reset after five accepted pairs aborts the operation
        begin
            int dn0;
            dn0 = done_cnt;
            @(negedge clk); start = 1'b1; x_in = 16'sd5000; y_in = 16'sd0;
            @(negedge clk); start = 1'b0; digit_ready = 1'b1;
            repeat (5) @(negedge clk);
            chk("mid_run_busy", int'(busy), 1);
            rst_n = 1'b0;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_valid", int'(digit_valid), 0);
            chk("abort_dx", int'(d_x), 0);
            chk("abort_done", int'(done), 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            digit_ready = 1'b0;
            repeat (2) @(negedge clk);
            chk("abort_no_done", done_cnt - dn0, 0);
            chk("abort_idle_busy", int'(busy), 0);
        end

        run_op(16'sd5000, 16'sd0, 2'b01, 2'b00, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
